// File: rtl/alu_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// alu_pkg: shared opcode, flag and width definitions for the add/sub datapath.
// Rev 1.0
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_ADC = 3'b010,
    OP_SBC = 3'b011,
    OP_INC = 3'b100,
    OP_DEC = 3'b101,
    OP_NEG = 3'b110,
    OP_CMP = 3'b111
  } alu_op_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

  // Carry-chaining ops and CMP keep the wrapped result even when saturation is on.
  function automatic logic is_sat_op(input alu_op_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC) ||
           (op == OP_DEC) || (op == OP_NEG);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_opnd_fmt.sv
`default_nettype none
// -----------------------------------------------------------------------------
// alu_opnd_fmt: combinational opcode to adder operand/carry-in mapping.
// Rev 1.0
// -----------------------------------------------------------------------------
module alu_opnd_fmt
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  alu_op_t        i_op,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  input  logic           i_c,
  output logic [W-1:0]   o_a,
  output logic [W-1:0]   o_b,
  output logic           o_cin
);

  always_comb begin
    o_a   = i_a;
    o_b   = i_b;
    o_cin = 1'b0;
    case (i_op)
      OP_ADD: ;
      OP_SUB, OP_CMP: begin
        o_b   = ~i_b;
        o_cin = 1'b1;
      end
      OP_ADC: o_cin = i_c;
      // Carry is not-borrow, so SBC reuses the subtract form with C as carry-in.
      OP_SBC: begin
        o_b   = ~i_b;
        o_cin = i_c;
      end
      OP_INC: begin
        o_b   = '0;
        o_cin = 1'b1;
      end
      OP_DEC: o_b = '1;
      OP_NEG: begin
        o_a   = '0;
        o_b   = ~i_a;
        o_cin = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_addsub_pipe.sv
`default_nettype none
// -----------------------------------------------------------------------------
// alu_addsub_pipe: two-stage valid/ready add/sub pipeline around an external
// prefix adder. Optional saturation enabled by defining ALU_SAT_EN. Rev 1.0
// -----------------------------------------------------------------------------
module alu_addsub_pipe
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     in_op,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  output logic           add_cin,
  input  logic [W-1:0]   add_s,
  input  logic           add_cout,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_res,
  output logic           out_wr,
  output logic           out_z,
  output logic           out_n,
  output logic           out_c,
  output logic           out_v,
  output logic           flag_c
);

  logic          r_s1_valid;
  alu_op_t       r_s1_op;
  logic [W-1:0]  r_s1_a;
  logic [W-1:0]  r_s1_b;
  logic          r_out_valid;
  logic [W-1:0]  r_out_res;
  logic          r_out_wr;
  alu_flags_t    r_out_flags;
  logic          r_flag_c;

  logic          w_adv;
  logic          w_in_fire;
  logic          w_v;
  logic [W-1:0]  w_res;

  assign w_adv     = r_s1_valid && (!r_out_valid || out_ready);
  assign in_ready  = !r_s1_valid || w_adv;
  assign w_in_fire = in_valid && in_ready;

  // Formatting reads the live carry flag, so an op entering stage 1 on the
  // same edge its predecessor moves to stage 2 already sees the new carry.
  alu_opnd_fmt #(.W(W)) u_fmt (
    .i_op  (r_s1_op),
    .i_a   (r_s1_a),
    .i_b   (r_s1_b),
    .i_c   (r_flag_c),
    .o_a   (add_a),
    .o_b   (add_b),
    .o_cin (add_cin)
  );

  assign w_v = (add_a[W-1] == add_b[W-1]) && (add_s[W-1] != add_a[W-1]);

  always_comb begin
    w_res = add_s;
`ifdef ALU_SAT_EN
    if (w_v && is_sat_op(r_s1_op)) begin
      w_res = add_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_op     <= OP_ADD;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_out_valid <= 1'b0;
      r_out_res   <= '0;
      r_out_wr    <= 1'b0;
      r_out_flags <= '0;
      r_flag_c    <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
        r_s1_op    <= alu_op_t'(in_op);
        r_s1_a     <= in_a;
        r_s1_b     <= in_b;
      end else if (w_adv) begin
        r_s1_valid <= 1'b0;
      end

      if (w_adv) begin
        r_out_valid   <= 1'b1;
        r_out_res     <= w_res;
        r_out_wr      <= (r_s1_op != OP_CMP);
        r_out_flags.z <= (w_res == '0);
        r_out_flags.n <= w_res[W-1];
        r_out_flags.c <= add_cout;
        r_out_flags.v <= w_v;
        r_flag_c      <= add_cout;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_res   = r_out_res;
  assign out_wr    = r_out_wr;
  assign out_z     = r_out_flags.z;
  assign out_n     = r_out_flags.n;
  assign out_c     = r_out_flags.c;
  assign out_v     = r_out_flags.v;
  assign flag_c    = r_flag_c;

endmodule
`default_nettype wire
